// File: rtl/dmem_ctrl_if.sv
// Bus bundle for dmem_ctrl: core LSU port (c), DMA/loader port (d) and the memory side.
// Latency: none, wires only.
// Backpressure: c_ready/d_ready are driven by the controller; requesters hold fields until accepted.
interface dmem_ctrl_if #(
  parameter int ADDR_WIDTH = 15
);
  // core port, byte addressed
  logic                  c_req;
  logic                  c_we;
  logic [ADDR_WIDTH+1:0] c_addr;
  logic [1:0]            c_size;
  logic                  c_unsigned;
  logic [31:0]           c_wdata;
  logic                  c_ready;
  logic                  c_rvalid;
  logic [31:0]           c_rdata;
  logic                  c_err;
  // DMA port, word addressed
  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [3:0]            d_wmask;
  logic [31:0]           d_wdata;
  logic                  d_ready;
  logic                  d_rvalid;
  logic [31:0]           d_rdata;
  // data memory (combinational read, byte-masked synchronous write)
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_data_in;
  logic [3:0]            mem_wmask;
  logic                  mem_we;
  logic [31:0]           mem_data_out;

  // controller view
  modport slave (
    input  c_req, c_we, c_addr, c_size, c_unsigned, c_wdata,
    output c_ready, c_rvalid, c_rdata, c_err,
    input  d_req, d_we, d_addr, d_wmask, d_wdata,
    output d_ready, d_rvalid, d_rdata,
    output mem_addr, mem_data_in, mem_wmask, mem_we,
    input  mem_data_out
  );

  // requester / memory-model view
  modport master (
    output c_req, c_we, c_addr, c_size, c_unsigned, c_wdata,
    input  c_ready, c_rvalid, c_rdata, c_err,
    output d_req, d_we, d_addr, d_wmask, d_wdata,
    input  d_ready, d_rvalid, d_rdata,
    input  mem_addr, mem_data_in, mem_wmask, mem_we,
    output mem_data_out
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory sequencer/arbiter: core (byte/half/word) and DMA (word) share one memory port.
// Latency: accept->rvalid 2 cycles aligned, 3 when a misaligned access is split into two beats.
// Backpressure: ready only in IDLE to one port; core wins ties unless DMA starved. Macro: DMEM_MISALIGN_EN.
module dmem_ctrl #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32,
  parameter int STARVE_MAX = 4
) (
  input logic        clk,
  input logic        rst,
  dmem_ctrl_if.slave bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC1 = 2'd1,
    ACC2 = 2'd2
  } state_t;

  state_t                state_q;
  logic [SW-1:0]         starve_q;

  // latched request
  logic                  is_d_q;
  logic                  we_q;
  logic [1:0]            off_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic                  bad_q;
  logic                  split_q;
  logic [DATA_WIDTH-1:0] wdata_hi_q;
  logic [3:0]            wmask_hi_q;
  logic [DATA_WIDTH-1:0] beat1_q;

  // registered outputs
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_data_in_q;
  logic [3:0]            mem_wmask_q;
  logic                  mem_we_q;
  logic                  c_rvalid_q;
  logic [DATA_WIDTH-1:0] c_rdata_q;
  logic                  c_err_q;
  logic                  d_rvalid_q;
  logic [DATA_WIDTH-1:0] d_rdata_q;

  // arbitration
  logic                  idle_ok;
  logic                  at_max;
  logic                  gnt_c;
  logic                  gnt_d;

  // core request decode
  logic [1:0]            c_off;
  logic                  c_half;
  logic                  c_word;
  logic [7:0]            c_ones;
  logic [7:0]            c_mask8;
  logic [63:0]           c_sh;
  logic                  c_split;
  logic                  c_bad;

  // load response
  logic [DATA_WIDTH-1:0] ld_lo;
  logic [DATA_WIDTH-1:0] ld_hi;
  logic [DATA_WIDTH-1:0] ld_raw;
  logic [DATA_WIDTH-1:0] ld_ext;
  logic [DATA_WIDTH-1:0] c_resp;

  assign idle_ok = (state_q == IDLE) && !rst;
  assign at_max  = (starve_q == SW'(STARVE_MAX));
  assign gnt_c   = idle_ok && bus.c_req && !(bus.d_req && at_max);
  assign gnt_d   = idle_ok && bus.d_req && (!bus.c_req || at_max);

  assign bus.c_ready  = gnt_c;
  assign bus.d_ready  = gnt_d;
  assign bus.c_rvalid = c_rvalid_q;
  assign bus.c_rdata  = c_rdata_q;
  assign bus.c_err    = c_err_q;
  assign bus.d_rvalid = d_rvalid_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_data_in = mem_data_in_q;
  // write strobes are cut as soon as reset is seen so a beat in flight never lands
  assign bus.mem_we    = mem_we_q && !rst;
  assign bus.mem_wmask = mem_wmask_q & {4{!rst}};

  // decode the core request: byte lanes, shifted store data, split/error classification
  always_comb begin
    c_off  = bus.c_addr[1:0];
    c_half = (bus.c_size == 2'b01);
    c_word = bus.c_size[1];
    case (bus.c_size)
      2'b00:   c_ones = 8'h01;
      2'b01:   c_ones = 8'h03;
      default: c_ones = 8'h0F;
    endcase
    c_mask8 = c_ones << c_off;
    c_sh    = {32'b0, bus.c_wdata} << {c_off, 3'b000};
`ifdef DMEM_MISALIGN_EN
    c_split = (c_half && (c_off == 2'b11)) || (c_word && (c_off != 2'b00));
    c_bad   = 1'b0;
`else
    c_split = 1'b0;
    c_bad   = (c_half && c_off[0]) || (c_word && (c_off != 2'b00));
`endif
  end

  // assemble the load result from the beat(s) read this access, then extend to 32 bits
  always_comb begin
    ld_lo  = (state_q == ACC1) ? bus.mem_data_out : beat1_q;
    ld_hi  = (state_q == ACC2) ? bus.mem_data_out : '0;
    ld_raw = 32'({ld_hi, ld_lo} >> {off_q, 3'b000});
    case (size_q)
      2'b00:   ld_ext = uns_q ? {24'b0, ld_raw[7:0]}  : {{24{ld_raw[7]}},  ld_raw[7:0]};
      2'b01:   ld_ext = uns_q ? {16'b0, ld_raw[15:0]} : {{16{ld_raw[15]}}, ld_raw[15:0]};
      default: ld_ext = ld_raw;
    endcase
    c_resp = (we_q || bad_q) ? '0 : ld_ext;
  end

  // sequencer: arbitration, beat generation, response and starvation counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      starve_q      <= '0;
      is_d_q        <= 1'b0;
      we_q          <= 1'b0;
      off_q         <= 2'b00;
      size_q        <= 2'b00;
      uns_q         <= 1'b0;
      bad_q         <= 1'b0;
      split_q       <= 1'b0;
      wdata_hi_q    <= '0;
      wmask_hi_q    <= 4'b0;
      beat1_q       <= '0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      mem_wmask_q   <= 4'b0;
      mem_we_q      <= 1'b0;
      c_rvalid_q    <= 1'b0;
      c_rdata_q     <= '0;
      c_err_q       <= 1'b0;
      d_rvalid_q    <= 1'b0;
      d_rdata_q     <= '0;
    end else begin
      c_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      c_err_q    <= 1'b0;

      // count core wins that made a waiting DMA request lose
      if (!bus.d_req || gnt_d) begin
        starve_q <= '0;
      end else if (gnt_c && !at_max) begin
        starve_q <= starve_q + SW'(1);
      end

      case (state_q)
        IDLE: begin
          if (gnt_c) begin
            is_d_q     <= 1'b0;
            we_q       <= bus.c_we;
            off_q      <= c_off;
            size_q     <= bus.c_size;
            uns_q      <= bus.c_unsigned;
            bad_q      <= c_bad;
            split_q    <= c_split;
            wdata_hi_q <= c_sh[63:32];
            wmask_hi_q <= c_mask8[7:4];
            state_q    <= ACC1;
            if (c_bad) begin
              // a rejected access never touches memory
              mem_we_q    <= 1'b0;
              mem_wmask_q <= 4'b0;
            end else begin
              mem_addr_q    <= bus.c_addr[ADDR_WIDTH+1:2];
              mem_data_in_q <= c_sh[31:0];
              mem_we_q      <= bus.c_we;
              mem_wmask_q   <= bus.c_we ? c_mask8[3:0] : 4'b0;
            end
          end else if (gnt_d) begin
            is_d_q        <= 1'b1;
            we_q          <= bus.d_we;
            off_q         <= 2'b00;
            size_q        <= 2'b10;
            uns_q         <= 1'b0;
            bad_q         <= 1'b0;
            split_q       <= 1'b0;
            mem_addr_q    <= bus.d_addr;
            mem_data_in_q <= bus.d_wdata;
            mem_we_q      <= bus.d_we;
            mem_wmask_q   <= bus.d_we ? bus.d_wmask : 4'b0;
            state_q       <= ACC1;
          end
        end

        ACC1: begin
          beat1_q <= bus.mem_data_out;
          if (split_q) begin
            // second beat at the next word; the address wraps at the top of memory
            mem_addr_q    <= mem_addr_q + ADDR_WIDTH'(1);
            mem_data_in_q <= wdata_hi_q;
            mem_wmask_q   <= we_q ? wmask_hi_q : 4'b0;
            state_q       <= ACC2;
          end else begin
            mem_we_q    <= 1'b0;
            mem_wmask_q <= 4'b0;
            state_q     <= IDLE;
            if (is_d_q) begin
              d_rvalid_q <= 1'b1;
              d_rdata_q  <= bus.mem_data_out;
            end else begin
              c_rvalid_q <= 1'b1;
              c_rdata_q  <= c_resp;
              c_err_q    <= bad_q;
            end
          end
        end

        ACC2: begin
          mem_we_q    <= 1'b0;
          mem_wmask_q <= 4'b0;
          state_q     <= IDLE;
          c_rvalid_q  <= 1'b1;
          c_rdata_q   <= c_resp;
          c_err_q     <= bad_q;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: table of core accesses plus hand-written corner sequences.
// Latency: checked per response against the accept cycle recorded by the scoreboard.
// Backpressure: requests are held until ready; arbitration fairness checked with both ports saturated.
module tb_dmem_ctrl;
  localparam int AW = 15;
`ifdef DMEM_MISALIGN_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  dmem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // memory model: combinational read, byte-masked write, plus a log of every write beat
  typedef struct {
    logic [AW-1:0] addr;
    logic [3:0]    mask;
    logic [31:0]   data;
  } wr_t;

  logic [31:0] tbmem [0:(1<<AW)-1];
  wr_t         wlog[$];

  assign bus.mem_data_out = tbmem[bus.mem_addr];

  always @(posedge clk) begin
    if (bus.mem_we) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_wmask[b]) tbmem[bus.mem_addr][8*b +: 8] <= bus.mem_data_in[8*b +: 8];
      wlog.push_back('{addr: bus.mem_addr, mask: bus.mem_wmask, data: bus.mem_data_in});
    end
  end

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // scoreboard: expected response pushed on accept, popped on rvalid
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          t;
    logic        chk_rd;
  } exp_t;

  exp_t cq[$];
  exp_t dq[$];
  exp_t cur_c;
  exp_t cur_d;
  exp_t mon_e;

  always @(negedge clk) begin
    if (bus.c_rvalid) begin
      if (cq.size() == 0) begin
        chk("c_unexpected_rvalid", 32'(bus.c_rvalid), 32'h0);
      end else begin
        mon_e = cq.pop_front();
        chk("c_rdata", bus.c_rdata, mon_e.rdata);
        chk("c_err", 32'(bus.c_err), 32'(mon_e.err));
        chk("c_latency", 32'(cyc - mon_e.t), 32'(mon_e.lat));
      end
    end
    if (bus.d_rvalid) begin
      if (dq.size() == 0) begin
        chk("d_unexpected_rvalid", 32'(bus.d_rvalid), 32'h0);
      end else begin
        mon_e = dq.pop_front();
        if (mon_e.chk_rd) chk("d_rdata", bus.d_rdata, mon_e.rdata);
        chk("d_latency", 32'(cyc - mon_e.t), 32'(mon_e.lat));
      end
    end
    if (bus.c_ready && bus.d_ready) chk("both_ready", 32'h1, 32'h0);
    if (bus.c_ready) begin
      mon_e = cur_c; mon_e.t = cyc; cq.push_back(mon_e);
    end
    if (bus.d_ready) begin
      mon_e = cur_d; mon_e.t = cyc; dq.push_back(mon_e);
    end
  end

  // issue one core access; returns one time unit after the accepting edge
  task automatic core_op(input logic we, input logic [AW+1:0] a, input logic [1:0] sz,
                         input logic u, input logic [31:0] wd,
                         input logic [31:0] er, input logic ee, input int lat);
    int k;
    cur_c = '{rdata: er, err: ee, lat: lat, t: 0, chk_rd: 1'b1};
    @(posedge clk); #1;
    bus.c_we = we; bus.c_addr = a; bus.c_size = sz; bus.c_unsigned = u; bus.c_wdata = wd;
    bus.c_req = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!bus.c_ready && k < 40);
    if (!bus.c_ready) chk("c_ready_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    bus.c_req = 1'b0;
  endtask

  task automatic d_op(input logic we, input logic [AW-1:0] a, input logic [3:0] m,
                      input logic [31:0] wd, input logic [31:0] er, input logic crd);
    int k;
    cur_d = '{rdata: er, err: 1'b0, lat: 2, t: 0, chk_rd: crd};
    @(posedge clk); #1;
    bus.d_we = we; bus.d_addr = a; bus.d_wmask = m; bus.d_wdata = wd;
    bus.d_req = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!bus.d_ready && k < 40);
    if (!bus.d_ready) chk("d_ready_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    bus.d_req = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((cq.size() != 0 || dq.size() != 0) && k < 50) begin @(negedge clk); k++; end
    chk("drain_outstanding", 32'(cq.size() + dq.size()), 32'h0);
  endtask

  typedef struct {
    logic          we;
    logic [AW+1:0] addr;
    logic [1:0]    size;
    logic          uns;
    logic [31:0]   wdata;
    logic [31:0]   exp_rdata;
    logic          exp_err;
    int            exp_lat;
  } vec_t;

  vec_t     tbl [20];
  logic [9:0] pat;
  int       ng;
  int       k;

  initial begin
    for (int i = 0; i < (1 << AW); i++) tbmem[i] = 32'h0;
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = '0; bus.c_size = 2'b00;
    bus.c_unsigned = 1'b0; bus.c_wdata = 32'h0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wmask = 4'h0; bus.d_wdata = 32'h0;
    cur_c = '{rdata: 32'h0, err: 1'b0, lat: 2, t: 0, chk_rd: 1'b1};
    cur_d = cur_c;
    rst = 1'b1;

    // reset state, with both requests raised to show ready is held off
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_c_ready", 32'(bus.c_ready), 32'h0);
    chk("rst_d_ready", 32'(bus.d_ready), 32'h0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
    chk("rst_mem_wmask", 32'(bus.mem_wmask), 32'h0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    chk("rst_mem_data_in", bus.mem_data_in, 32'h0);
    chk("rst_rvalids", 32'({bus.c_rvalid, bus.d_rvalid, bus.c_err}), 32'h0);
    chk("rst_c_rdata", bus.c_rdata, 32'h0);
    @(posedge clk); #1;
    bus.c_req = 1'b0; bus.d_req = 1'b0;
    rst = 1'b0;

    // table: {we, byte addr, size, unsigned, wdata, expected rdata, expected err, latency}
    tbl[0]  = '{1'b1, 17'h00006, 2'b00, 1'b0, 32'h000000A5, 32'h0,         1'b0, 2};
    tbl[1]  = '{1'b0, 17'h00006, 2'b00, 1'b0, 32'h0,        32'hFFFFFFA5,  1'b0, 2};
    tbl[2]  = '{1'b0, 17'h00006, 2'b00, 1'b1, 32'h0,        32'h000000A5,  1'b0, 2};
    tbl[3]  = '{1'b1, 17'h00010, 2'b01, 1'b0, 32'h00008001, 32'h0,         1'b0, 2};
    tbl[4]  = '{1'b0, 17'h00010, 2'b01, 1'b0, 32'h0,        32'hFFFF8001,  1'b0, 2};
    tbl[5]  = '{1'b0, 17'h00010, 2'b01, 1'b1, 32'h0,        32'h00008001,  1'b0, 2};
    tbl[6]  = '{1'b1, 17'h00020, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0,         1'b0, 2};
    tbl[7]  = '{1'b0, 17'h00020, 2'b10, 1'b0, 32'h0,        32'hDEADBEEF,  1'b0, 2};
    tbl[8]  = '{1'b0, 17'h00021, 2'b00, 1'b0, 32'h0,        32'hFFFFFFBE,  1'b0, 2};
    tbl[9]  = '{1'b0, 17'h00023, 2'b00, 1'b1, 32'h0,        32'h000000DE,  1'b0, 2};
    tbl[10] = '{1'b0, 17'h00020, 2'b11, 1'b0, 32'h0,        32'hDEADBEEF,  1'b0, 2};
    tbl[11] = '{1'b1, 17'h00003, 2'b10, 1'b0, 32'h11223344, 32'h0,         !MIS, MIS ? 3 : 2};
    tbl[12] = '{1'b0, 17'h00003, 2'b10, 1'b0, 32'h0,        MIS ? 32'h11223344 : 32'h0, !MIS, MIS ? 3 : 2};
    tbl[13] = '{1'b0, 17'h00006, 2'b00, 1'b0, 32'h0,        MIS ? 32'h00000011 : 32'hFFFFFFA5, 1'b0, 2};
    tbl[14] = '{1'b1, 17'h1FFFF, 2'b01, 1'b0, 32'h0000BEEF, 32'h0,         !MIS, MIS ? 3 : 2};
    tbl[15] = '{1'b0, 17'h1FFFF, 2'b01, 1'b1, 32'h0,        MIS ? 32'h0000BEEF : 32'h0, !MIS, MIS ? 3 : 2};
    tbl[16] = '{1'b0, 17'h00000, 2'b00, 1'b1, 32'h0,        MIS ? 32'h000000BE : 32'h0, 1'b0, 2};
    tbl[17] = '{1'b1, 17'h00041, 2'b01, 1'b0, 32'h00001234, 32'h0,         !MIS, 2};
    tbl[18] = '{1'b0, 17'h00041, 2'b01, 1'b0, 32'h0,        MIS ? 32'h00001234 : 32'h0, !MIS, 2};
    tbl[19] = '{1'b0, 17'h00042, 2'b01, 1'b0, 32'h0,        MIS ? 32'h00000012 : 32'h0, 1'b0, 2};

    for (int i = 0; i < 20; i++)
      core_op(tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].uns, tbl[i].wdata,
              tbl[i].exp_rdata, tbl[i].exp_err, tbl[i].exp_lat);
    drain();

    // byte store lane placement
    wlog.delete();
    core_op(1'b1, 17'h00006, 2'b00, 1'b0, 32'h000000A5, 32'h0, 1'b0, 2);
    drain();
    chk("byte_st_beats", 32'(wlog.size()), 32'd1);
    if (wlog.size() >= 1) begin
      chk("byte_st_addr", 32'(wlog[0].addr), 32'h1);
      chk("byte_st_mask", 32'(wlog[0].mask), 32'b0100);
      chk("byte_st_data", wlog[0].data, 32'h00A50000);
    end

    // word store at byte 3: two beats when splitting, none otherwise
    wlog.delete();
    core_op(1'b1, 17'h00003, 2'b10, 1'b0, 32'h11223344, 32'h0, !MIS, MIS ? 3 : 2);
    drain();
    chk("split_st_beats", 32'(wlog.size()), MIS ? 32'd2 : 32'd0);
`ifdef DMEM_MISALIGN_EN
    if (wlog.size() >= 2) begin
      chk("split_b1_addr", 32'(wlog[0].addr), 32'h0);
      chk("split_b1_mask", 32'(wlog[0].mask), 32'b1000);
      chk("split_b1_data", wlog[0].data, 32'h44000000);
      chk("split_b2_addr", 32'(wlog[1].addr), 32'h1);
      chk("split_b2_mask", 32'(wlog[1].mask), 32'b0111);
      chk("split_b2_data", wlog[1].data, 32'h00112233);
    end
`endif

    // half store at the last byte wraps to word 0
    wlog.delete();
    core_op(1'b1, 17'h1FFFF, 2'b01, 1'b0, 32'h0000BEEF, 32'h0, !MIS, MIS ? 3 : 2);
    drain();
    chk("wrap_st_beats", 32'(wlog.size()), MIS ? 32'd2 : 32'd0);
`ifdef DMEM_MISALIGN_EN
    if (wlog.size() >= 2) begin
      chk("wrap_b1_addr", 32'(wlog[0].addr), 32'h7FFF);
      chk("wrap_b1_mask", 32'(wlog[0].mask), 32'b1000);
      chk("wrap_b1_data", wlog[0].data, 32'hEF000000);
      chk("wrap_b2_addr", 32'(wlog[1].addr), 32'h0);
      chk("wrap_b2_mask", 32'(wlog[1].mask), 32'b0001);
      chk("wrap_b2_data", wlog[1].data, 32'h000000BE);
    end
`endif

    // DMA: full store, masked store, then load of the raw word with the core idle
    wlog.delete();
    d_op(1'b1, 15'd5, 4'b1111, 32'hCAFEF00D, 32'h0, 1'b0);
    d_op(1'b1, 15'd5, 4'b0010, 32'h0000AA00, 32'h0, 1'b0);
    drain();
    chk("dma_st_beats", 32'(wlog.size()), 32'd2);
    if (wlog.size() >= 1) begin
      chk("dma_st_addr", 32'(wlog[0].addr), 32'd5);
      chk("dma_st_mask", 32'(wlog[0].mask), 32'b1111);
      chk("dma_st_data", wlog[0].data, 32'hCAFEF00D);
    end
    d_op(1'b0, 15'd5, 4'b0000, 32'h0, 32'hCAFEAA0D, 1'b1);
    drain();

    // both ports saturated: four core grants then one DMA grant, repeating
    cur_c = '{rdata: 32'hDEADBEEF, err: 1'b0, lat: 2, t: 0, chk_rd: 1'b1};
    cur_d = '{rdata: 32'hCAFEAA0D, err: 1'b0, lat: 2, t: 0, chk_rd: 1'b1};
    @(posedge clk); #1;
    bus.c_we = 1'b0; bus.c_addr = 17'h00020; bus.c_size = 2'b10; bus.c_unsigned = 1'b0;
    bus.d_we = 1'b0; bus.d_addr = 15'd5;
    bus.c_req = 1'b1; bus.d_req = 1'b1;
    pat = '0; ng = 0; k = 0;
    while (ng < 10 && k < 200) begin
      @(negedge clk); k++;
      if (bus.d_ready) begin pat[ng] = 1'b1; ng++; end
      else if (bus.c_ready) ng++;
    end
    @(posedge clk); #1;
    bus.c_req = 1'b0; bus.d_req = 1'b0;
    chk("arb_grants", 32'(ng), 32'd10);
    chk("arb_pattern", 32'(pat), 32'h210);
    drain();

    // reset in the middle of an access: nothing further written, no response
`ifdef DMEM_MISALIGN_EN
    core_op(1'b1, 17'h00103, 2'b10, 1'b0, 32'hCAFEBABE, 32'h0, 1'b0, 3);
    @(posedge clk); #1;
`else
    core_op(1'b1, 17'h00100, 2'b10, 1'b0, 32'hCAFEBABE, 32'h0, 1'b0, 2);
`endif
    rst = 1'b1;
    cq.delete();
    @(negedge clk);
    chk("rst_mid_mem_we", 32'(bus.mem_we), 32'h0);
    chk("rst_mid_mem_wmask", 32'(bus.mem_wmask), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid_c_rvalid", 32'(bus.c_rvalid), 32'h0);
    chk("rst_mid_mem_addr", 32'(bus.mem_addr), 32'h0);
    chk("rst_mid_mem_data_in", bus.mem_data_in, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_word40", tbmem[15'h40], MIS ? 32'hBE000000 : 32'h0);
    chk("rst_mid_word41", tbmem[15'h41], 32'h0);
    core_op(1'b0, 17'h00100, 2'b10, 1'b0, 32'h0, MIS ? 32'hBE000000 : 32'h0, 1'b0, 2);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", n_bad);
    $fatal(1);
  end

endmodule
